// File: rtl/traffic_pkg.sv
// Shared phase encoding, default timing and lamp decode for the traffic phase scheduler.
package traffic_pkg;

  typedef enum logic [2:0] {
    PhNsGreen  = 3'd0,
    PhNsYellow = 3'd1,
    PhArNe     = 3'd2,
    PhEwGreen  = 3'd3,
    PhEwYellow = 3'd4,
    PhArEn     = 3'd5,
    PhPedWalk  = 3'd6
  } phase_e;

  localparam int unsigned DefMinGreen   = 8;
  localparam int unsigned DefNsGreenMax = 32;
  localparam int unsigned DefEwGreenMax = 16;
  localparam int unsigned DefYellowTime = 4;
  localparam int unsigned DefAllRedTime = 2;
  localparam int unsigned DefPedTime    = 8;

  typedef struct packed {
    logic ns_red;
    logic ns_yellow;
    logic ns_green;
    logic ew_red;
    logic ew_yellow;
    logic ew_green;
    logic ped_walk;
  } lamps_t;

  // Both directions default to red; only the owning direction is lit otherwise.
  function automatic lamps_t lamp_decode(phase_e ph);
    lamps_t l;
    l        = '0;
    l.ns_red = 1'b1;
    l.ew_red = 1'b1;
    case (ph)
      PhNsGreen: begin
        l.ns_red   = 1'b0;
        l.ns_green = 1'b1;
      end
      PhNsYellow: begin
        l.ns_red    = 1'b0;
        l.ns_yellow = 1'b1;
      end
      PhEwGreen: begin
        l.ew_red   = 1'b0;
        l.ew_green = 1'b1;
      end
      PhEwYellow: begin
        l.ew_red    = 1'b0;
        l.ew_yellow = 1'b1;
      end
      PhPedWalk: l.ped_walk = 1'b1;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating tick counter: counts enabled cycles up to a per-phase limit, cleared on phase change.
module phase_timer #(
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [Width-1:0] limit_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q < limit_i)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase FSM with latched pedestrian request and registered lamp outputs.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN    = DefMinGreen,
  parameter int unsigned NS_GREEN_MAX = DefNsGreenMax,
  parameter int unsigned EW_GREEN_MAX = DefEwGreenMax,
  parameter int unsigned YELLOW_TIME  = DefYellowTime,
  parameter int unsigned ALL_RED_TIME = DefAllRedTime,
  parameter int unsigned PED_TIME     = DefPedTime
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_NS_vehicle_detect,
  input  logic       i_EW_vehicle_detect,
  input  logic       i_ped_req,
  output logic       o_NS_red,
  output logic       o_NS_yellow,
  output logic       o_NS_green,
  output logic       o_EW_red,
  output logic       o_EW_yellow,
  output logic       o_EW_green,
  output logic       o_ped_walk,
  output logic [2:0] o_phase
);

  localparam int unsigned MaxGreen = (NS_GREEN_MAX > EW_GREEN_MAX) ? NS_GREEN_MAX : EW_GREEN_MAX;
  localparam int unsigned MaxClr   = (YELLOW_TIME > ALL_RED_TIME) ? YELLOW_TIME : ALL_RED_TIME;
  localparam int unsigned MaxOther = (MaxClr > PED_TIME) ? MaxClr : PED_TIME;
  localparam int unsigned MaxTime  = (MaxGreen > MaxOther) ? MaxGreen : MaxOther;
  localparam int unsigned Tw       = ($clog2(MaxTime) > 0) ? $clog2(MaxTime) : 1;

  localparam logic [Tw-1:0] MinLimit = Tw'(MIN_GREEN - 1);
  localparam logic [Tw-1:0] NsLimit  = Tw'(NS_GREEN_MAX - 1);
  localparam logic [Tw-1:0] EwLimit  = Tw'(EW_GREEN_MAX - 1);
  localparam logic [Tw-1:0] YLimit   = Tw'(YELLOW_TIME - 1);
  localparam logic [Tw-1:0] ArLimit  = Tw'(ALL_RED_TIME - 1);
  localparam logic [Tw-1:0] PedLimit = Tw'(PED_TIME - 1);

  if (MIN_GREEN < 1 || NS_GREEN_MAX < 1 || EW_GREEN_MAX < 1 || YELLOW_TIME < 1 ||
      ALL_RED_TIME < 1 || PED_TIME < 1 || MIN_GREEN > EW_GREEN_MAX ||
      MIN_GREEN > NS_GREEN_MAX) begin : gen_param_check
    $error("traffic_phase_scheduler: illegal timing parameters");
  end

  phase_e        phase_q, phase_d;
  logic          ped_q, ped_d;
  lamps_t        lamps_q;
  logic [Tw-1:0] t;
  logic [Tw-1:0] limit;
  logic          timer_clr;

  phase_timer #(
    .Width(Tw)
  ) u_timer (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .en_i   (i_tick),
    .clr_i  (timer_clr),
    .limit_i(limit),
    .count_o(t)
  );

  // The limit doubles as the saturation point, so the rest phase parks at NS_GREEN_MAX-1.
  always_comb begin
    phase_d = phase_q;
    limit   = '0;
    case (phase_q)
      PhNsGreen: begin
        limit = NsLimit;
        if (i_tick && (i_EW_vehicle_detect || ped_q) &&
            ((t == NsLimit) || ((t >= MinLimit) && !i_NS_vehicle_detect))) begin
          phase_d = PhNsYellow;
        end
      end
      PhNsYellow: begin
        limit = YLimit;
        if (i_tick && (t == YLimit)) phase_d = PhArNe;
      end
      PhArNe: begin
        limit = ArLimit;
        if (i_tick && (t == ArLimit)) phase_d = PhEwGreen;
      end
      PhEwGreen: begin
        limit = EwLimit;
        if (i_tick && ((t == EwLimit) || ((t >= MinLimit) && !i_EW_vehicle_detect))) begin
          phase_d = PhEwYellow;
        end
      end
      PhEwYellow: begin
        limit = YLimit;
        if (i_tick && (t == YLimit)) phase_d = PhArEn;
      end
      PhArEn: begin
        limit = ArLimit;
        if (i_tick && (t == ArLimit)) phase_d = ped_q ? PhPedWalk : PhNsGreen;
      end
      PhPedWalk: begin
        limit = PedLimit;
        if (i_tick && (t == PedLimit)) phase_d = PhNsGreen;
      end
      default: phase_d = PhNsGreen;
    endcase
  end

  assign timer_clr = (phase_d != phase_q);

  // Entry into the walk wins over a same-cycle request; requests during the walk are dropped.
  always_comb begin
    ped_d = ped_q;
    if ((phase_d == PhPedWalk) && (phase_q != PhPedWalk)) begin
      ped_d = 1'b0;
    end else if ((phase_q != PhPedWalk) && i_ped_req) begin
      ped_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_q <= PhNsGreen;
      ped_q   <= 1'b0;
      lamps_q <= lamp_decode(PhNsGreen);
    end else begin
      phase_q <= phase_d;
      ped_q   <= ped_d;
      lamps_q <= lamp_decode(phase_d);
    end
  end

  assign o_NS_red    = lamps_q.ns_red;
  assign o_NS_yellow = lamps_q.ns_yellow;
  assign o_NS_green  = lamps_q.ns_green;
  assign o_EW_red    = lamps_q.ew_red;
  assign o_EW_yellow = lamps_q.ew_yellow;
  assign o_EW_green  = lamps_q.ew_green;
  assign o_ped_walk  = lamps_q.ped_walk;
  assign o_phase     = phase_q;

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Synchronous phase scheduler for a two-road intersection with a pedestrian crossing. It sequences the NS and EW lamp sets through green, yellow and all-red clearance, and serves a latched pedestrian request. Phase durations are counted in ticks of an external timebase strobe. It replaces per-direction ripple counters with one registered FSM and a shared phase timer, and it drives the lamp outputs directly.

## Interface
- MIN_GREEN, 8: minimum green for either direction, in ticks
- NS_GREEN_MAX, 32: maximum NS green under competing demand, in ticks
- EW_GREEN_MAX, 16: maximum EW green, in ticks
- YELLOW_TIME, 4: yellow duration, in ticks
- ALL_RED_TIME, 2: all-red clearance, in ticks
- PED_TIME, 8: pedestrian walk duration, in ticks
- i_clk  in  1  single clock; all state changes on the rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_tick  in  1  one-cycle timebase strobe; timers advance only when it is high
- i_NS_vehicle_detect  in  1  NS demand, level
- i_EW_vehicle_detect  in  1  EW demand, level
- i_ped_req  in  1  pedestrian button, any-length pulse
- o_NS_red / o_NS_yellow / o_NS_green  out  1 each  NS lamps, one-hot
- o_EW_red / o_EW_yellow / o_EW_green  out  1 each  EW lamps, one-hot
- o_ped_walk  out  1  walk lamp
- o_phase  out  3  current phase code

## Operation
- Phase codes:
  - NS_GREEN=0
  - NS_YELLOW=1
  - AR_NE=2 (all-red, NS to EW)
  - EW_GREEN=3
  - EW_YELLOW=4
  - AR_EN=5 (all-red, EW to NS)
  - PED_WALK=6
  - Code 7 is illegal and recovers to NS_GREEN on the next edge.
- NS_GREEN is the rest phase. With no demand, the controller stays there and the timer saturates at NS_GREEN_MAX-1.
- Phase timer ("t"):
  - Increments on each cycle where i_tick is high.
  - Clears to 0 on every phase change.
  - Saturates; it never wraps.
- ped_pending:
  - Set by i_ped_req in any phase except PED_WALK.
  - Cleared on entry to PED_WALK.
  - A request during PED_WALK, including the entry cycle, is ignored.
- Transitions. All require i_tick=1 in the deciding cycle.
  - NS_GREEN→NS_YELLOW requires both:
    - EW_detect or ped_pending, and
    - t==NS_GREEN_MAX-1, or (t≥MIN_GREEN-1 and !NS_detect).
  - NS_YELLOW→AR_NE: t==YELLOW_TIME-1.
  - AR_NE→EW_GREEN: t==ALL_RED_TIME-1.
  - EW_GREEN→EW_YELLOW: t==EW_GREEN_MAX-1, or (t≥MIN_GREEN-1 and !EW_detect). This exit is unconditional; EW always returns to NS.
  - EW_YELLOW→AR_EN: t==YELLOW_TIME-1.
  - AR_EN→PED_WALK if ped_pending, else →NS_GREEN, at t==ALL_RED_TIME-1.
  - PED_WALK→NS_GREEN: t==PED_TIME-1.
- Lamp decode, registered from the next state:
  - Green or yellow is lit only for the direction owning the phase; the other direction is red.
  - AR_NE, AR_EN and PED_WALK show both directions red.
  - o_ped_walk=1 only in PED_WALK.
- Exactly one lamp per direction is lit in every cycle, including reset.
- Reset values:
  - Phase NS_GREEN, t=0, ped_pending=0.
  - o_NS_green=1, o_EW_red=1, all other lamps 0.
  - o_ped_walk=0, o_phase=0.
- Reset mid-phase: outputs go to reset values immediately (asynchronously), and ped_pending is lost.
- Parameters must satisfy: all ≥1, MIN_GREEN ≤ EW_GREEN_MAX, MIN_GREEN ≤ NS_GREEN_MAX. Elaboration fails otherwise.

## Timing
- Each phase lasts exactly N ticks, where N is its parameter or the gap/max exit point. The phase change happens on the clock edge of the Nth tick.
- Outputs and o_phase change on that same edge: zero cycles from the deciding edge, with no combinational input-to-output path.
- Detect inputs are sampled only in the deciding cycle.
- i_ped_req is latched in the cycle it is high. A request in the same cycle as the AR_EN exit decision is not served that cycle: the exit goes to NS_GREEN and the request stays pending.
- i_tick held low freezes the phase and the timer indefinitely.
- Timer width is $clog2 of the largest timing parameter.

## Structure
- Package traffic_pkg holds:
  - Phase enum and its 3-bit encoding.
  - Default timing constants.
  - A lamp-decode function.
- One sub-module, phase_timer: saturating tick counter with clear, enable=i_tick, width parameter.
- The FSM, ped_pending and the output registers live in traffic_phase_scheduler.

## Test plan
- Reset with i_tick=1 every cycle and no demand: o_NS_green=1, o_EW_red=1, o_phase=0, held for 100 cycles.
- EW_detect=1, NS_detect=0 held: NS_GREEN 8 ticks, NS_YELLOW 4, AR_NE 2, EW_GREEN 16 (max-out), EW_YELLOW 4, AR_EN 2, then NS_GREEN.
- Both detects held: NS_GREEN lasts exactly 32 ticks; EW_GREEN lasts 16.
- One-cycle i_ped_req in NS_GREEN, no vehicles: sequence is NS 8, Y 4, AR 2, EW 8 (gap-out), Y 4, AR 2, PED_WALK 8, then NS_GREEN. ped_pending is 0 afterwards, and a second pulse during the walk produces no second walk.
- i_tick toggling every 3rd cycle: phase durations scale to 3×N cycles, and lamps change only on tick edges.
- i_rst_n low mid EW_GREEN: lamps return to NS green / EW red without waiting for a clock edge. After release, NS_GREEN restarts with t=0.
